// File: rtl/mem_access_ctrl.sv
// Purpose : single-initiator main-memory sequencer (MAR/MBR) behind one request/response handshake.
// Latency : load 3 cycles, store 2 cycles, out-of-range (bounds check on) 1 cycle from acceptance to rsp_valid.
// Backpr. : one request in flight; req_ready only in IDLE; response held stable until rsp_ready.
//
// Ports: clk/reset (async active-low); req_valid/req_ready/req_write/req_addr/req_wdata (request);
//        rsp_valid/rsp_ready/rsp_rdata/rsp_err (response); mem_addr/mem_wdata/mem_write_enable/mem_rdata
//        (synchronous single-port memory, read data registered one edge after the address); mar/mbr (observation).
// Option : define MEM_BOUNDS_CHECK_EN to reject addresses >= MEM_DEPTH with rsp_err instead of wrapping them.
module mem_access_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 16384
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mar,
  output logic [DATA_W-1:0] mbr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state;
  logic   wr_flag;   // latched req_write for the request in flight
  logic   err_flag;  // request was rejected as out of range
  logic   addr_oob;

`ifdef MEM_BOUNDS_CHECK_EN
  // One extra bit so MEM_DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(MEM_DEPTH);

  assign addr_oob = ({1'b0, req_addr} >= DEPTH_EXT);
  assign mem_addr = mar;
  assign rsp_err  = rsp_valid & err_flag;
`else
  localparam int              IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'((64'd1 << IDX_W) - 64'd1);

  assign addr_oob = 1'b0;
  // Keep only the low index bits so out-of-range addresses wrap onto the array.
  assign mem_addr = mar & ADDR_MASK;
  assign rsp_err  = 1'b0;
`endif

  assign mem_wdata = mbr;
  // Rejected requests return zero data regardless of what MBR captured.
  assign rsp_rdata = err_flag ? '0 : mbr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      mar              <= '0;
      mbr              <= '0;
      wr_flag          <= 1'b0;
      err_flag         <= 1'b0;
      req_ready        <= 1'b1;
      rsp_valid        <= 1'b0;
      mem_write_enable <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            mar       <= req_addr;
            wr_flag   <= req_write;
            req_ready <= 1'b0;
            if (req_write) mbr <= req_wdata;
            if (addr_oob) begin
              // Skip the memory entirely; respond on the next cycle.
              err_flag  <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              // Write strobe is registered here so it is high for exactly the ISSUE cycle.
              mem_write_enable <= req_write;
              state            <= ISSUE;
            end
          end
        end
        ISSUE: begin
          mem_write_enable <= 1'b0;
          if (wr_flag) begin
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // Memory registered the read at the end of ISSUE; capture it now.
          mbr       <= mem_rdata;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            err_flag  <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory access controller that acts as the initiator on the main memory port: it accepts load/store requests from the CPU control unit, sequences them through MAR/MBR, and drives the synchronous single-port memory (`addr`, `data_in`, `write_enable`, `data_out`). It sits between the fetch/execute control FSM and main memory. It replaces ad-hoc per-instruction memory sequencing with one request/response handshake that is shared by all instructions.

## Interface
- `ADDR_W`, 16, address width of requests and of MAR.
- `DATA_W`, 16, data width of MBR and the memory word.
- `MEM_DEPTH`, 16384, number of memory words; valid addresses are 0..MEM_DEPTH-1.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_W  word address.
- `req_wdata`  in  DATA_W  store data.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_rdata`  out  DATA_W  loaded data (loads) or echoed store data (stores).
- `rsp_err`  out  1  address out of range (see Configuration).
- `mem_addr`  out  ADDR_W  to memory `addr`.
- `mem_wdata`  out  DATA_W  to memory `data_in`.
- `mem_write_enable`  out  1  to memory `write_enable`.
- `mem_rdata`  in  DATA_W  from memory `data_out`; registered by the memory one edge after the address is presented.
- `mar`  out  ADDR_W  MAR contents, for observation.
- `mbr`  out  DATA_W  MBR contents, for observation.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Held in an internal state register with no output port.
- IDLE: `req_ready`=1. On `req_valid`: MAR<=`req_addr`, MBR<=`req_wdata` for a store, latch `req_write`, go to ISSUE.
- ISSUE:
  - `mem_write_enable` = latched write flag.
  - Store: memory writes MBR at MAR on this edge; go to RESP.
  - Load: memory samples MAR on this edge; go to WAIT.
- WAIT (loads only): MBR<=`mem_rdata`; go to RESP.
- RESP: `rsp_valid`=1 and `rsp_rdata`=MBR. These hold stable until `rsp_ready`=1, then the FSM goes to IDLE.
- `mem_addr` = MAR and `mem_wdata` = MBR at all times (combinational).
- `mem_write_enable` is asserted only in ISSUE for a store, for exactly one cycle per store.
- `req_ready` is low in ISSUE, WAIT and RESP. A request presented in RESP is not accepted, even when `rsp_ready`=1 in the same cycle; it is accepted in the following IDLE cycle.
- `rsp_err` is valid only while `rsp_valid`=1, and is 0 otherwise.

## Timing
- Reset (`reset`=0), applied asynchronously:
  - State returns to IDLE.
  - MAR, MBR, `rsp_rdata`, `mem_addr` and `mem_wdata` go to 0.
  - `rsp_valid`, `rsp_err` and `mem_write_enable` go to 0; `req_ready` goes to 1.
- Reset during ISSUE deasserts `mem_write_enable` immediately, so an in-flight store is aborted. No response is produced for an aborted request.
- Load latency: request accepted at edge E0; `rsp_valid` rises after E2, i.e. 3 cycles.
- Store latency: `rsp_valid` rises after E1, i.e. 2 cycles.
- Throughput with `rsp_ready` tied high:
  - 1 load per 4 cycles.
  - 1 store per 3 cycles.
- Widths: `req_addr` is zero-extended or truncated to ADDR_W; there is no arithmetic on data.

## Configuration
- Macro: `MEM_BOUNDS_CHECK_EN`.
- Defined:
  - At acceptance, `req_addr` >= MEM_DEPTH routes IDLE -> RESP directly; no ISSUE and no memory access, so `mem_write_enable` never asserts.
  - In RESP, `rsp_err`=1 and `rsp_rdata`=0.
  - Response latency for an out-of-range request is 1 cycle.
- Undefined:
  - `rsp_err` is tied to 0.
  - `mem_addr` = MAR modulo MEM_DEPTH (low log2(MEM_DEPTH) bits, zero-extended), so out-of-range addresses wrap.

## Test plan
- Store 0x1234 to 0x0010, then load 0x0010 -> store response 2 cycles after acceptance with `rsp_rdata`=0x1234. Load response 3 cycles after acceptance with `rsp_rdata`=0x1234 and `rsp_err`=0.
- Back-to-back loads of 0x0001 (holding 0xAAAA) and 0x0002 (holding 0x5555) with `req_valid` held high and `rsp_ready`=1 -> responses 0xAAAA then 0x5555, 4 cycles apart. `req_ready` is high only in IDLE.
- Load with `rsp_ready` held low for 5 cycles -> `rsp_valid` and `rsp_rdata` stay stable for all 5 cycles. `req_ready` stays 0. The FSM returns to IDLE one cycle after `rsp_ready` rises.
- Store 0xBEEF to 0x4000:
  - With `MEM_BOUNDS_CHECK_EN`: `rsp_err`=1 after 1 cycle, `mem_write_enable` never asserted, memory[0] unchanged.
  - Without: 0xBEEF lands at memory[0] and `rsp_err`=0.
- Store 0x0F0F to 0x3FFF, then load 0x3FFF -> 0x0F0F read back and `rsp_err`=0 in both builds.
- Assert `reset`=0 during ISSUE of a store to 0x0020 (prior value 0x0000) -> `mem_write_enable` drops immediately. All outputs go to reset values, no `rsp_valid` is produced, and a subsequent load of 0x0020 returns 0x0000.
